// File: rtl/fifo_read_ctrl.sv
// Read-side pointer and flag controller for the async FIFO.
// Syncs the write Gray pointer in; drives read address, Gray read pointer and status.
module fifo_read_ctrl #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                     rd_clk,
  input  logic                     rd_rst,
  input  logic                     rd_en,
  input  logic [ADDRESS_WIDTH:0]   rd_wr_ptr_gray,
  output logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [ADDRESS_WIDTH:0]   rd_ptr,
  output logic                     fifo_empty,
  output logic                     fifo_aempty,
  output logic [ADDRESS_WIDTH:0]   rd_level,
  output logic                     rd_valid,
  output logic                     rd_underflow
);

  localparam int PW = ADDRESS_WIDTH + 1;
  localparam logic [PW-1:0] AE_THR = PW'(AEMPTY_THRESH);

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] rd_q_wr_ptr;
  logic [PW-1:0] rd_ptr_bin;
  logic [PW-1:0] rd_ptr_bin_nxt;
  logic [PW-1:0] rd_gray_nxt;
  logic [PW-1:0] wr_bin;
  logic [PW-1:0] level_nxt;
  logic          rd_acc;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Plain flop chain; the Gray source changes one bit per step.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= rd_wr_ptr_gray;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign rd_q_wr_ptr = sync_q[SYNC_STAGES-1];

  always_comb begin
    rd_acc         = rd_en & ~fifo_empty;
    rd_ptr_bin_nxt = rd_ptr_bin + {{ADDRESS_WIDTH{1'b0}}, rd_acc};
    rd_gray_nxt    = rd_ptr_bin_nxt ^ (rd_ptr_bin_nxt >> 1);
    wr_bin         = gray2bin(rd_q_wr_ptr);
    level_nxt      = wr_bin - rd_ptr_bin_nxt;
  end

  // Flags and level are computed from the post-read pointer.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rd_ptr_bin   <= '0;
      rd_ptr       <= '0;
      fifo_empty   <= 1'b1;
      fifo_aempty  <= 1'b1;
      rd_level     <= '0;
      rd_valid     <= 1'b0;
      rd_underflow <= 1'b0;
    end else begin
      rd_ptr_bin   <= rd_ptr_bin_nxt;
      rd_ptr       <= rd_gray_nxt;
      fifo_empty   <= (rd_gray_nxt == rd_q_wr_ptr);
      fifo_aempty  <= (level_nxt <= AE_THR);
      rd_level     <= level_nxt;
      rd_valid     <= rd_acc;
      rd_underflow <= rd_underflow | (rd_en & fifo_empty);
    end
  end

  assign rd_addr = rd_ptr_bin[ADDRESS_WIDTH-1:0];

endmodule
